// File: rtl/interrupt_ack_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer_pkg
// Shared definitions for the 8259-style interrupt acknowledge sequencer:
// FSM state encoding, IR line count, the spurious id and the one-hot to id
// encoder used both when latching the acknowledged line and when setting isr.
// No ports (package).
// -----------------------------------------------------------------------------
package interrupt_ack_sequencer_pkg;

    localparam int NUM_IRQ = 8;

    // Plain vector encoding keeps the state register legacy-compatible.
    typedef logic [2:0] stateT;
    localparam stateT IDLE = 3'd0;
    localparam stateT REQ  = 3'd1;
    localparam stateT ACK1 = 3'd2;
    localparam stateT GAP  = 3'd3;
    localparam stateT ACK2 = 3'd4;

    // An acknowledge with no pending request reports the lowest-priority line.
    localparam logic [2:0] SPURIOUS_ID = 3'd7;

    // Encodes a one-hot request into its line number; returns 0 for all-zero.
    function automatic logic [2:0] encodeId(input logic [NUM_IRQ-1:0] vec);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec[i]) id = i[2:0];
        end
        return id;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_isr_register.sv
// -----------------------------------------------------------------------------
// isr_register
// In-service register. A bit is set when its line is acknowledged and cleared
// by a specific EOI, a non-specific EOI (lowest set bit) or an automatic EOI.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   setValid, setId       set isr[setId] this cycle
//   eoiValid              one-cycle EOI command strobe
//   eoiSpecific, eoiLevel specific EOI clears isr[eoiLevel]; else lowest set bit
//   aeoiClear, aeoiId     automatic EOI clears isr[aeoiId]
//   isr                   in-service register
// -----------------------------------------------------------------------------
module isr_register
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               setValid,
    input  logic [2:0]         setId,
    input  logic               eoiValid,
    input  logic               eoiSpecific,
    input  logic [2:0]         eoiLevel,
    input  logic               aeoiClear,
    input  logic [2:0]         aeoiId,
    output logic [NUM_IRQ-1:0] isr
);

    logic [NUM_IRQ-1:0] setMask;
    logic [NUM_IRQ-1:0] eoiMask;
    logic [NUM_IRQ-1:0] clearMask;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        setMask = '0;
        eoiMask = '0;
        if (setValid) setMask = 8'd1 << setId;
        if (eoiValid) begin
            // isr & -isr isolates the lowest set bit, i.e. the highest-priority level in service.
            eoiMask = eoiSpecific ? (8'd1 << eoiLevel) : (isr & (~isr + 8'd1));
        end
        clearMask = eoiMask | (aeoiClear ? (8'd1 << aeoiId) : 8'd0);
    end

    // Clear is applied before set, so a bit set and cleared together stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            isr <= (isr & ~clearMask) | setMask;
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
// Runs the two-pulse INTA handshake: raises INT for a pending request, latches
// and acknowledges the winning line on the first INTA, drives the vector byte
// on the second INTA, and optionally performs automatic EOI.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   interruptVector   one-hot winning request (all-zero = none)
//   inta_n            CPU acknowledge strobe, active low, synchronous to clk
//   vectorBase        ICW2 T7..T3
//   aeoiMode          automatic EOI enable
//   eoiValid, eoiSpecific, eoiLevel   OCW2 EOI command
//   intOut            INT to the CPU
//   isr               in-service register
//   irqAck            one-cycle one-hot clear pulse to the IRR
//   dataOut, dataOutEn  vector byte and data-bus drive enable
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter int NUM_IRQ = interrupt_ack_sequencer_pkg::NUM_IRQ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] interruptVector,
    input  logic               inta_n,
    input  logic [4:0]         vectorBase,
    input  logic               aeoiMode,
    input  logic               eoiValid,
    input  logic               eoiSpecific,
    input  logic [2:0]         eoiLevel,
    output logic               intOut,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] irqAck,
    output logic [7:0]         dataOut,
    output logic               dataOutEn
);

    stateT       state;
    stateT       nextState;
    logic        intaPrev;
    logic        intaFall;
    logic        intaRise;
    logic        ackStrobe;
    logic        setValid;
    logic        aeoiClear;
    logic        anyRequest;
    logic [2:0]  latchedId;
    logic [4:0]  latchedBase;
    logic        latchedSpurious;

    assign anyRequest = |interruptVector;
    assign intaFall   = intaPrev & ~inta_n;
    assign intaRise   = ~intaPrev & inta_n;

    // First INTA fall while requesting; a real line is only acknowledged if one is pending.
    assign ackStrobe  = (state == REQ) && intaFall;
    assign setValid   = ackStrobe && anyRequest;
    assign aeoiClear  = (state == ACK2) && intaRise && aeoiMode && !latchedSpurious;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (anyRequest) nextState = REQ;
            REQ: begin
                // The fall takes priority so a request withdrawn at the fall becomes spurious.
                if (intaFall)         nextState = ACK1;
                else if (!anyRequest) nextState = IDLE;
            end
            ACK1:    if (intaRise) nextState = GAP;
            GAP:     if (intaFall) nextState = ACK2;
            ACK2:    if (intaRise) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            intaPrev        <= 1'b1;
            irqAck          <= '0;
            // NOTE: the latched id/base are reset too, so a sequence abandoned by reset leaves no stale vector behind.
            latchedId       <= 3'd0;
            latchedBase     <= 5'd0;
            latchedSpurious <= 1'b0;
        end else begin
            state    <= nextState;
            intaPrev <= inta_n;
            irqAck   <= setValid ? interruptVector : '0;
            // Id and base are frozen here and held until the next acknowledge.
            if (ackStrobe) begin
                latchedId       <= anyRequest ? encodeId(interruptVector) : SPURIOUS_ID;
                latchedBase     <= vectorBase;
                latchedSpurious <= !anyRequest;
            end
        end
    end

    isr_register uIsrRegister (
        .clk         (clk),
        .rst_n       (rst_n),
        .setValid    (setValid),
        .setId       (encodeId(interruptVector)),
        .eoiValid    (eoiValid),
        .eoiSpecific (eoiSpecific),
        .eoiLevel    (eoiLevel),
        .aeoiClear   (aeoiClear),
        .aeoiId      (latchedId),
        .isr         (isr)
    );

    // Outputs decode straight from the state register; the bus enable follows inta_n with no added cycle.
    assign intOut    = (state == REQ);
    assign dataOutEn = (state == ACK2) && !inta_n;
    assign dataOut   = (state == ACK2) ? {latchedBase, latchedId} : 8'h00;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ack_sequencer
// Directed bench for interrupt_ack_sequencer. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when outputs are sampled,
// 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] interruptVector;
    logic       inta_n;
    logic [4:0] vectorBase;
    logic       aeoiMode;
    logic       eoiValid;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;
    logic       intOut;
    logic [7:0] isr;
    logic [7:0] irqAck;
    logic [7:0] dataOut;
    logic       dataOutEn;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] expQ[$];
    logic [7:0]  isrModel;

    interrupt_ack_sequencer #(.NUM_IRQ(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .interruptVector (interruptVector),
        .inta_n          (inta_n),
        .vectorBase      (vectorBase),
        .aeoiMode        (aeoiMode),
        .eoiValid        (eoiValid),
        .eoiSpecific     (eoiSpecific),
        .eoiLevel        (eoiLevel),
        .intOut          (intOut),
        .isr             (isr),
        .irqAck          (irqAck),
        .dataOut         (dataOut),
        .dataOutEn       (dataOutEn)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [31:0] value);
        expQ.push_back(value);
    endtask

    task automatic check(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, observed);
        end else begin
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
        end
    endtask

    // Full two-pulse acknowledge. ackVec is the request present at the first
    // INTA fall (0 = spurious); an optional specific EOI is issued on that edge.
    task automatic runAck(input logic [7:0] reqVec, input logic [7:0] ackVec,
                          input logic [4:0] base, input logic eoiAtFall,
                          input logic [2:0] eoiLvl);
        logic [2:0] id;
        logic       spur;
        spur = (ackVec == 8'h00);
        id   = 3'd7;
        if (!spur) begin
            for (int i = 0; i < 8; i++) if (ackVec[i]) id = i[2:0];
        end

        vectorBase      = base;
        interruptVector = reqVec;
        pushExp(1);
        tick();
        check("intOut_req", intOut);

        interruptVector = ackVec;
        inta_n          = 1'b0;
        if (eoiAtFall) begin
            eoiValid    = 1'b1;
            eoiSpecific = 1'b1;
            eoiLevel    = eoiLvl;
            isrModel    = isrModel & ~(8'd1 << eoiLvl);
        end
        isrModel = isrModel | ackVec;
        pushExp(0); pushExp(ackVec); pushExp(isrModel); pushExp(0);
        tick();
        eoiValid = 1'b0;
        check("intOut_ack1", intOut);
        check("irqAck_ack1", irqAck);
        check("isr_ack1", isr);
        check("dataOutEn_ack1", dataOutEn);

        // A changing request must not disturb the latched id.
        interruptVector = 8'h01;
        pushExp(0);
        tick();
        check("irqAck_pulse_end", irqAck);

        inta_n = 1'b1;
        pushExp(0);
        tick();
        check("dataOut_gap", dataOut);

        inta_n = 1'b0;
        pushExp({base, id}); pushExp(1);
        tick();
        check("dataOut_ack2", dataOut);
        check("dataOutEn_ack2", dataOutEn);

        interruptVector = 8'h00;
        inta_n          = 1'b1;
        pushExp(0);
        #1;
        check("dataOutEn_rise", dataOutEn);

        if (aeoiMode && !spur) isrModel = isrModel & ~(8'd1 << id);
        pushExp(isrModel); pushExp(0); pushExp(0);
        tick();
        check("isr_end", isr);
        check("dataOut_idle", dataOut);
        check("intOut_idle", intOut);
    endtask

    task automatic doEoi(input logic specific, input logic [2:0] lvl);
        logic found;
        eoiValid    = 1'b1;
        eoiSpecific = specific;
        eoiLevel    = lvl;
        if (specific) begin
            isrModel = isrModel & ~(8'd1 << lvl);
        end else begin
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (!found && isrModel[i]) begin
                    isrModel[i] = 1'b0;
                    found = 1'b1;
                end
            end
        end
        pushExp(isrModel);
        tick();
        eoiValid = 1'b0;
        check("isr_eoi", isr);
    endtask

    initial begin
        rst_n           = 1'b0;
        interruptVector = 8'h00;
        inta_n          = 1'b1;
        vectorBase      = 5'b00001;
        aeoiMode        = 1'b0;
        eoiValid        = 1'b0;
        eoiSpecific     = 1'b0;
        eoiLevel        = 3'd0;
        isrModel        = 8'h00;

        // Reset state
        repeat (2) tick();
        pushExp(0); pushExp(0); pushExp(0); pushExp(0); pushExp(0);
        check("rst_intOut", intOut);
        check("rst_isr", isr);
        check("rst_irqAck", irqAck);
        check("rst_dataOut", dataOut);
        check("rst_dataOutEn", dataOutEn);
        rst_n = 1'b1;
        tick();

        // Basic acknowledge of IR3, vector 0x0B
        runAck(8'h08, 8'h08, 5'b00001, 1'b0, 3'd0);

        // Request withdrawn before any INTA
        interruptVector = 8'h08;
        pushExp(1);
        tick();
        check("intOut_withdraw_req", intOut);
        interruptVector = 8'h00;
        pushExp(0); pushExp(8'h08);
        tick();
        check("intOut_withdrawn", intOut);
        check("isr_withdrawn", isr);

        // INTA in IDLE is ignored
        inta_n = 1'b0;
        pushExp(0); pushExp(8'h08); pushExp(0);
        tick();
        check("irqAck_idle_inta", irqAck);
        check("isr_idle_inta", isr);
        check("intOut_idle_inta", intOut);
        inta_n = 1'b1;
        pushExp(0);
        tick();
        check("dataOutEn_idle_inta", dataOutEn);

        // Second line in service -> isr 0x28, then EOIs
        runAck(8'h20, 8'h20, 5'b00001, 1'b0, 3'd0);
        doEoi(1'b0, 3'd0);
        doEoi(1'b1, 3'd5);
        doEoi(1'b0, 3'd0);

        // Automatic EOI
        aeoiMode = 1'b1;
        runAck(8'h08, 8'h08, 5'b00001, 1'b0, 3'd0);
        aeoiMode = 1'b0;

        // Spurious acknowledge, vector 0x87
        runAck(8'h08, 8'h00, 5'b10000, 1'b0, 3'd0);

        // Set and clear in the same cycle: different bits both apply, same bit set wins
        runAck(8'h08, 8'h08, 5'b00001, 1'b0, 3'd0);
        runAck(8'h20, 8'h20, 5'b00001, 1'b1, 3'd3);
        runAck(8'h08, 8'h08, 5'b00001, 1'b1, 3'd3);

        // Reset between the two INTA pulses
        interruptVector = 8'h04;
        tick();
        inta_n = 1'b0;
        tick();
        interruptVector = 8'h00;
        inta_n = 1'b1;
        tick();
        rst_n = 1'b0;
        pushExp(0); pushExp(0); pushExp(0); pushExp(0); pushExp(0);
        #1;
        check("midrst_intOut", intOut);
        check("midrst_isr", isr);
        check("midrst_irqAck", irqAck);
        check("midrst_dataOut", dataOut);
        check("midrst_dataOutEn", dataOutEn);
        isrModel = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        runAck(8'h04, 8'h04, 5'b00010, 1'b0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of IR lines; only 8 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port interruptVector  input  8  one-hot winning request from the priority resolver; all-zero means no request.
REQ-005 SHALL have port inta_n  input  1  CPU interrupt-acknowledge strobe, active low, already synchronous to clk.
REQ-006 SHALL have port vectorBase  input  5  ICW2 bits T7..T3.
REQ-007 SHALL have port aeoiMode  input  1  automatic-EOI enable from ICW4.
REQ-008 SHALL have ports eoiValid  input  1 (one-cycle OCW2 EOI strobe), eoiSpecific  input  1, and eoiLevel  input  3.
REQ-009 SHALL have port intOut  output  1  INT request to the CPU, active high.
REQ-010 SHALL have port isr  output  8  in-service register.
REQ-011 SHALL have port irqAck  output  8  one-cycle one-hot pulse telling the IRR to clear the acknowledged line.
REQ-012 SHALL have ports dataOut  output  8 (vector byte) and dataOutEn  output  1 (data-bus drive enable).

Function
REQ-013 SHALL implement an FSM with states IDLE, REQ, ACK1, GAP, ACK2.
REQ-014 SHALL detect INTA edges by comparing inta_n with a registered copy: fall = prev 1 / now 0; rise = prev 0 / now 1.
REQ-015 IDLE SHALL go to REQ and assert intOut the cycle after interruptVector is nonzero.
REQ-016 REQ SHALL return to IDLE and deassert intOut if interruptVector goes to zero before an INTA fall.
REQ-017 On INTA fall in REQ, SHALL go to ACK1, latch the encoded id (0..7) of interruptVector, set the matching isr bit, pulse irqAck for exactly one cycle, and deassert intOut.
REQ-018 If interruptVector is zero at the first INTA fall, SHALL latch id 7 (spurious) and SHALL NOT set isr or pulse irqAck.
REQ-019 ACK1 SHALL go to GAP on INTA rise; GAP SHALL go to ACK2 on the next INTA fall.
REQ-020 In ACK2, SHALL drive dataOut = {vectorBase, latched id} and hold dataOutEn high while inta_n is low, with zero-cycle combinational enable from the state register.
REQ-021 ACK2 SHALL go to IDLE on INTA rise; if aeoiMode=1 and the acknowledge was not spurious, SHALL clear the latched isr bit in that same cycle.
REQ-022 dataOut SHALL be 0 and dataOutEn 0 in every state other than ACK2.
REQ-023 Latched id and vectorBase sampling SHALL NOT change between ACK1 and the end of ACK2, regardless of interruptVector changes.
REQ-024 A non-specific EOI (eoiValid=1, eoiSpecific=0) SHALL clear the lowest-index set isr bit; if isr is zero, no effect.
REQ-025 A specific EOI SHALL clear isr[eoiLevel].
REQ-026 When an isr bit is set and cleared in the same cycle, the set SHALL win; set and clear of different bits SHALL both apply.
REQ-027 INTA edges in IDLE SHALL be ignored, with no isr or irqAck change.

Reset
REQ-028 While rst_n=0, SHALL force state IDLE, intOut=0, isr=0, irqAck=0, dataOut=0, dataOutEn=0, latched id=0, and prev inta_n=1, asynchronously.
REQ-029 A reset asserted mid-sequence SHALL abandon the acknowledge, and after release the block SHALL restart in IDLE.

Structure
REQ-030 A shared package SHALL hold the state encoding type, NUM_IRQ, the spurious id constant 3'd7, and the one-hot-to-id encode function.
REQ-031 SHALL instantiate one sub-module isr_register, which owns the isr set/clear logic and EOI lowest-bit selection.

Verification
REQ-032 interruptVector=8'h08, vectorBase=5'b00001, two INTA pulses -> intOut high then low, irqAck=8'h08 for one cycle, isr=8'h08, dataOut=8'h0B during the second pulse.
REQ-033 Same as REQ-032 with aeoiMode=1 -> isr returns to 8'h00 on the second INTA rise.
REQ-034 interruptVector drops to 0 after intOut is asserted, before any INTA -> intOut=0, return to IDLE, isr unchanged.
REQ-035 First INTA with interruptVector=0 (spurious), vectorBase=5'b10000 -> dataOut=8'h87, isr=0, no irqAck.
REQ-036 isr=8'h28, non-specific EOI -> isr=8'h20; then specific EOI level 5 -> isr=8'h00.
REQ-037 rst_n low between the two INTA pulses -> all outputs 0 immediately; the next request completes normally.
